// File: rtl/debounce_filter_n.sv
// debounce_filter_n: multi-channel input debounce filter.
// Each channel has an optional synchroniser and a run-length counter.
// The debounced output q follows the synchronised input only after the
// new level has held for STABLE_CYCLES consecutive clocks.
// The channels share no state.
// Optional feature macro: DEBOUNCE_GLITCH_CNT_EN adds an 8-bit saturating
// per-channel count of aborted candidates, with a synchronous clear.
module debounce_filter_n #(
  parameter int   CHANNELS      = 4,
  parameter int   STABLE_CYCLES = 30,
  parameter int   SYNC_STAGES   = 2,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CHANNELS-1:0]   d,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  input  logic                  glitch_clr,
  output logic [CHANNELS*8-1:0] glitch_cnt,
`endif
  output logic [CHANNELS-1:0]   q,
  output logic [CHANNELS-1:0]   rise,
  output logic [CHANNELS-1:0]   fall,
  output logic [CHANNELS-1:0]   busy
);

  // The counter only has to reach STABLE_CYCLES-1, because it clears on the terminal match.
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic             s;
      logic             q_reg, q_next;
      logic             rise_reg, rise_next;
      logic             fall_reg, fall_next;
      logic             busy_reg;
      logic [CNT_W-1:0] cnt_reg, cnt_next;

      if (SYNC_STAGES == 0) begin : g_nosync
        assign s = d[gi];
      end else begin : g_sync
        logic [SYNC_STAGES-1:0] sync_reg;

        // Shift the raw input through the synchroniser chain.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            sync_reg <= {SYNC_STAGES{RESET_VAL}};
          end else begin
            sync_reg[0] <= d[gi];
            for (int k = 1; k < SYNC_STAGES; k++) begin
              sync_reg[k] <= sync_reg[k-1];
            end
          end
        end

        assign s = sync_reg[SYNC_STAGES-1];
      end

      // Decide the next state of the candidate counter, q and the event pulses.
      // Any return to the current level drops the candidate.
      always_comb begin
        cnt_next  = '0;
        q_next    = q_reg;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (s != q_reg) begin
          if (cnt_reg == CNT_LAST) begin
            q_next    = s;
            rise_next = s;
            fall_next = ~s;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end

      // Register the filter state. busy mirrors the counter that is being loaded.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg  <= '0;
          q_reg    <= RESET_VAL;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          busy_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          q_reg    <= q_next;
          rise_reg <= rise_next;
          fall_reg <= fall_next;
          busy_reg <= (cnt_next != '0);
        end
      end

      assign q[gi]    = q_reg;
      assign rise[gi] = rise_reg;
      assign fall[gi] = fall_reg;
      assign busy[gi] = busy_reg;

`ifdef DEBOUNCE_GLITCH_CNT_EN
      logic [7:0] glitch_reg;
      logic       abort;

      // A candidate is aborted when the input returns to q while the counter is running.
      assign abort = (s == q_reg) && (cnt_reg != '0);

      // Count aborted candidates, saturating at 255. A clear overrides an increment in the same cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          glitch_reg <= 8'd0;
        end else if (glitch_clr) begin
          glitch_reg <= 8'd0;
        end else if (abort && (glitch_reg != 8'hFF)) begin
          glitch_reg <= glitch_reg + 8'd1;
        end
      end

      assign glitch_cnt[8*gi +: 8] = glitch_reg;
`endif
    end
  endgenerate

endmodule

// File: doc/debounce_filter_n.md
Name: debounce_filter_n

Overview:
Parametrised multi-channel input debounce filter. It is the successor to the team's single-channel 30-cycle filter, adding:
- configurable channel count, stable-time and synchroniser depth;
- asynchronous active-low reset;
- per-channel rise/fall event pulses.

It sits between raw board inputs (buttons, switches, mechanical contacts) and the control logic. Each channel's output changes only after its input has held a new level for STABLE_CYCLES consecutive clocks.

Parameters:
CHANNELS, 4, number of independent filter channels (>=1)
STABLE_CYCLES, 30, consecutive cycles a new level must hold before q follows (1..65535)
SYNC_STAGES, 2, input synchroniser flops per channel (0..3; 0 = input already synchronous)
RESET_VAL, 0, level q takes in reset; replicated to all channels (0 or 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous assert, active-low
d  input  CHANNELS  raw inputs, one bit per channel
q  output  CHANNELS  debounced levels
rise  output  CHANNELS  one-cycle pulse when q[i] goes 0->1
fall  output  CHANNELS  one-cycle pulse when q[i] goes 1->0
busy  output  CHANNELS  high while channel i is counting a candidate level (cnt[i] != 0)

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low: assertion takes effect immediately, independent of clk; release is sampled on clk.
- In reset:
  - q = all RESET_VAL;
  - rise, fall, busy = 0;
  - synchroniser flops = RESET_VAL;
  - all counters = 0.
- Per channel i, fully independent, no shared state.
- Synchroniser: s[i] = d[i] delayed through SYNC_STAGES flops. When SYNC_STAGES = 0, s[i] = d[i] directly.
- Counter cnt[i]: width CNT_W = max(1, clog2(STABLE_CYCLES)), unsigned.
- Rule applied on each clk edge (not in reset):
  - s[i] == q[i]: cnt[i] <= 0; q held; this covers glitch rejection, since any return to the current level aborts the candidate.
  - s[i] != q[i] and cnt[i] == STABLE_CYCLES-1: q[i] <= s[i]; cnt[i] <= 0; rise[i] or fall[i] <= 1 for exactly that one cycle.
  - s[i] != q[i] otherwise: cnt[i] <= cnt[i] + 1.
- rise/fall are registered. Each is high only in the cycle q[i] has just changed, and they are never both high on one channel.
- busy[i] is registered and equals (cnt[i] != 0).
- Latency: with d[i] changed and held from before clk edge 1, q[i] changes at edge STABLE_CYCLES + SYNC_STAGES. Defaults give edge 32.
- STABLE_CYCLES = 1: q follows s with one cycle of delay and busy is always 0.
- Counter cannot wrap: it is cleared on the terminal match, and saturation is unreachable.
- Reset asserted mid-count: all counters are cleared immediately, and q returns to RESET_VAL even if a transition was about to complete.
- Simultaneous transitions on several channels: each channel completes independently; multiple rise/fall bits may be high in the same cycle.

Optional Feature:
DEBOUNCE_GLITCH_CNT_EN
- Defined:
  - adds ports glitch_clr (input, 1) and glitch_cnt (output, CHANNELS*8; channel i in bits [8i+7:8i]);
  - each channel has an 8-bit saturating counter that increments by 1 on every aborted candidate (s[i] == q[i] while cnt[i] != 0) and holds at 255;
  - glitch_clr = 1 clears all glitch counters on the next edge, taking priority over a same-cycle increment;
  - reset value of the glitch counters is 0.
- Undefined: these ports and all associated logic are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 with d=4'hF and RESET_VAL=0 -> q=0, rise=fall=busy=0 immediately, without waiting for clk; after release, q[3:0] rises at edge 32 with rise=4'hF for one cycle.
- Clean step: d[0] 0->1 held (defaults) -> q[0]=1 after edge 32; rise[0]=1 only in that cycle; busy[0] high for edges 3..31.
- Glitch: d[1] high for 20 cycles, then low -> q[1] stays 0, no rise pulse, busy[1] drops; with DEBOUNCE_GLITCH_CNT_EN, glitch_cnt[15:8]=1.
- Falling edge and independence: q[2]=1 settled, d[2] to 0 while d[3] toggles every 10 cycles -> q[2]=0 and fall[2]=1 at edge 32; q[3] never changes.
- Mid-count reset: d[0] held high, rst_n pulsed low at cycle 25 for 1 cycle -> q[0]=0, cnt restarts, q[0] rises 32 edges after rst_n release.
- Glitch saturation (macro on): 300 aborted candidates on channel 0 -> glitch_cnt[7:0]=255; glitch_clr=1 concurrent with an abort -> 0.
